// File: rtl/ahb_arbiter_param.sv
// AHB-Lite multi-master arbiter and bus mux: fixed-priority or round-robin grant,
// HLOCK and fixed-length burst protection, address/data-phase ownership tracking.
module ahb_arbiter_param #(
  parameter int unsigned NUM_M   = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RR_MODE = 1,
  parameter int unsigned DEF_M   = 0,
  parameter int unsigned MW      = 3
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic [NUM_M-1:0]           HBUSREQ,
  input  logic [NUM_M-1:0]           HLOCK,
  input  logic [NUM_M*ADDR_W-1:0]    HADDR_M,
  input  logic [NUM_M*2-1:0]         HTRANS_M,
  input  logic [NUM_M-1:0]           HWRITE_M,
  input  logic [NUM_M*3-1:0]         HSIZE_M,
  input  logic [NUM_M*3-1:0]         HBURST_M,
  input  logic [NUM_M*DATA_W-1:0]    HWDATA_M,
  input  logic                       HREADY_S,
  output logic [NUM_M-1:0]           HGRANT,
  output logic [MW-1:0]              HMASTER,
  output logic                       HMASTLOCK,
  output logic [ADDR_W-1:0]          HADDR_S,
  output logic [1:0]                 HTRANS_S,
  output logic                       HWRITE_S,
  output logic [2:0]                 HSIZE_S,
  output logic [2:0]                 HBURST_S,
  output logic [DATA_W-1:0]          HWDATA_S
);

  localparam int unsigned      CNT_W     = 4;
  localparam logic [1:0]       TR_IDLE   = 2'b00;
  localparam logic [1:0]       TR_NONSEQ = 2'b10;
  localparam logic [1:0]       TR_SEQ    = 2'b11;
  localparam logic [MW-1:0]    DEF_IDX   = MW'(DEF_M);
  localparam logic [NUM_M-1:0] GNT_RST   = NUM_M'(1) << DEF_M;

  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} burst_state_e;

  burst_state_e       state_q, state_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [NUM_M-1:0]   grant_q, grant_d;
  logic [MW-1:0]      hmaster_q, hmaster_d;
  logic [MW-1:0]      data_own_q, data_own_d;
  logic               mastlock_q, mastlock_d;
  logic [MW-1:0]      rr_ptr_q, rr_ptr_d;

  logic [MW-1:0]      gnt_idx;
  logic               lock_own;
  logic               lock_gnt;
  logic [NUM_M-1:0]   req_hi;
  logic               any_req;
  logic [MW-1:0]      win_idx;
  logic [CNT_W-1:0]   burst_len;
  logic               burst_load;
  logic               lock_hold;
  logic               arb_en;

  function automatic logic [MW-1:0] lowest_idx(input logic [NUM_M-1:0] v);
    lowest_idx = '0;
    for (int i = int'(NUM_M) - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = MW'(i);
    end
  endfunction

  // Index of the current grant and lock requests of grant / address-phase owners
  always_comb begin
    gnt_idx  = '0;
    lock_gnt = HLOCK[0];
    lock_own = HLOCK[0];
    for (int i = 0; i < int'(NUM_M); i++) begin
      if (grant_q[i]) begin
        gnt_idx  = MW'(i);
        lock_gnt = HLOCK[i];
      end
      if (MW'(i) == hmaster_q) lock_own = HLOCK[i];
    end
  end

  // Winner: requesters above rr_ptr first (round-robin), else lowest index
  always_comb begin
    req_hi = '0;
    for (int i = 0; i < int'(NUM_M); i++) begin
      req_hi[i] = HBUSREQ[i] && (MW'(i) > rr_ptr_q);
    end
    any_req = |HBUSREQ;
    win_idx = DEF_IDX;
    if (any_req) begin
      if ((RR_MODE != 0) && (|req_hi)) win_idx = lowest_idx(req_hi);
      else                             win_idx = lowest_idx(HBUSREQ);
    end
  end

  // Address/control follow HMASTER, write data follows the data-phase owner
  always_comb begin
    HADDR_S  = HADDR_M[ADDR_W-1:0];
    HTRANS_S = HTRANS_M[1:0];
    HWRITE_S = HWRITE_M[0];
    HSIZE_S  = HSIZE_M[2:0];
    HBURST_S = HBURST_M[2:0];
    HWDATA_S = HWDATA_M[DATA_W-1:0];
    for (int i = 0; i < int'(NUM_M); i++) begin
      if (MW'(i) == hmaster_q) begin
        HADDR_S  = HADDR_M[i*ADDR_W +: ADDR_W];
        HTRANS_S = HTRANS_M[i*2 +: 2];
        HWRITE_S = HWRITE_M[i];
        HSIZE_S  = HSIZE_M[i*3 +: 3];
        HBURST_S = HBURST_M[i*3 +: 3];
      end
      if (MW'(i) == data_own_q) HWDATA_S = HWDATA_M[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    case (HBURST_S)
      3'b010, 3'b011: burst_len = CNT_W'(3);
      3'b100, 3'b101: burst_len = CNT_W'(7);
      3'b110, 3'b111: burst_len = CNT_W'(15);
      default:        burst_len = '0;
    endcase
  end

  // Beat counter FSM; a loading NONSEQ also blocks arbitration on its own edge
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    burst_load = 1'b0;
    if (HREADY_S) begin
      case (state_q)
        ST_IDLE: begin
          if ((HTRANS_S == TR_NONSEQ) && (burst_len != '0)) begin
            burst_load = 1'b1;
            beat_cnt_d = burst_len;
            state_d    = ST_BURST;
          end
        end
        ST_BURST: begin
          if (HTRANS_S == TR_IDLE) begin
            beat_cnt_d = '0;
            state_d    = ST_IDLE;
          end else if (HTRANS_S == TR_SEQ) begin
            beat_cnt_d = beat_cnt_q - CNT_W'(1);
            if (beat_cnt_q == CNT_W'(1)) state_d = ST_IDLE;
          end else if (HTRANS_S == TR_NONSEQ) begin
            if (burst_len != '0) begin
              burst_load = 1'b1;
              beat_cnt_d = burst_len;
            end else begin
              beat_cnt_d = '0;
              state_d    = ST_IDLE;
            end
          end
        end
        default: begin
          beat_cnt_d = '0;
          state_d    = ST_IDLE;
        end
      endcase
    end
  end

  assign lock_hold = lock_own && (HTRANS_S != TR_IDLE);
  assign arb_en    = HREADY_S && !lock_hold && (beat_cnt_q == '0) && !burst_load;

  // Grant, pointer and ownership pipeline
  always_comb begin
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    hmaster_d  = hmaster_q;
    data_own_d = data_own_q;
    mastlock_d = mastlock_q;
    if (arb_en) begin
      for (int i = 0; i < int'(NUM_M); i++) begin
        grant_d[i] = (MW'(i) == win_idx);
      end
      if (any_req && (RR_MODE != 0)) rr_ptr_d = win_idx;
    end
    if (HREADY_S) begin
      hmaster_d  = gnt_idx;
      data_own_d = hmaster_q;
      mastlock_d = lock_gnt;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      grant_q    <= GNT_RST;
      hmaster_q  <= DEF_IDX;
      data_own_q <= DEF_IDX;
      mastlock_q <= 1'b0;
      rr_ptr_q   <= DEF_IDX;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      grant_q    <= grant_d;
      hmaster_q  <= hmaster_d;
      data_own_q <= data_own_d;
      mastlock_q <= mastlock_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter_param.sv
// Directed bench for ahb_arbiter_param: round-robin and fixed-priority instances
// share one stimulus; expected values are hand-derived per cycle.
module tb_ahb_arbiter_param;

  localparam int unsigned NM = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 3;
  localparam logic [1:0]  T_IDLE   = 2'b00;
  localparam logic [1:0]  T_NONSEQ = 2'b10;
  localparam logic [1:0]  T_SEQ    = 2'b11;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          hready = 1'b1;
  logic [NM-1:0] busreq = '0;
  logic [NM-1:0] lock = '0;
  logic [1:0]    trans [NM];
  logic [2:0]    burst [NM];
  logic [AW-1:0] addr  [NM];
  logic [DW-1:0] wdata [NM];

  logic [NM*AW-1:0] haddr_m;
  logic [NM*2-1:0]  htrans_m;
  logic [NM-1:0]    hwrite_m;
  logic [NM*3-1:0]  hsize_m;
  logic [NM*3-1:0]  hburst_m;
  logic [NM*DW-1:0] hwdata_m;

  logic [NM-1:0] rr_gnt,    fp_gnt;
  logic [MW-1:0] rr_hmst,   fp_hmst;
  logic          rr_mlock,  fp_mlock;
  logic [AW-1:0] rr_haddr,  fp_haddr;
  logic [1:0]    rr_htrans, fp_htrans;
  logic          rr_hwrite, fp_hwrite;
  logic [2:0]    rr_hsize,  fp_hsize;
  logic [2:0]    rr_hburst, fp_hburst;
  logic [DW-1:0] rr_hwdata, fp_hwdata;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_g [5] = '{1, 2, 3, 0, 1};
  int exp_h [5] = '{0, 1, 2, 3, 0};
  int exp_d [5] = '{0, 0, 1, 2, 3};

  always #5 HCLK = ~HCLK;

  always_comb begin
    haddr_m  = '0;
    htrans_m = '0;
    hsize_m  = '0;
    hburst_m = '0;
    hwdata_m = '0;
    for (int i = 0; i < int'(NM); i++) begin
      haddr_m[i*AW +: AW] = addr[i];
      htrans_m[i*2 +: 2]  = trans[i];
      hsize_m[i*3 +: 3]   = 3'b010;
      hburst_m[i*3 +: 3]  = burst[i];
      hwdata_m[i*DW +: DW] = wdata[i];
    end
  end
  assign hwrite_m = '1;

  ahb_arbiter_param #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .DEF_M(0), .MW(MW)) u_rr (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(busreq), .HLOCK(lock),
    .HADDR_M(haddr_m), .HTRANS_M(htrans_m), .HWRITE_M(hwrite_m), .HSIZE_M(hsize_m),
    .HBURST_M(hburst_m), .HWDATA_M(hwdata_m), .HREADY_S(hready),
    .HGRANT(rr_gnt), .HMASTER(rr_hmst), .HMASTLOCK(rr_mlock), .HADDR_S(rr_haddr),
    .HTRANS_S(rr_htrans), .HWRITE_S(rr_hwrite), .HSIZE_S(rr_hsize), .HBURST_S(rr_hburst),
    .HWDATA_S(rr_hwdata)
  );

  ahb_arbiter_param #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .DEF_M(0), .MW(MW)) u_fp (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(busreq), .HLOCK(lock),
    .HADDR_M(haddr_m), .HTRANS_M(htrans_m), .HWRITE_M(hwrite_m), .HSIZE_M(hsize_m),
    .HBURST_M(hburst_m), .HWDATA_M(hwdata_m), .HREADY_S(hready),
    .HGRANT(fp_gnt), .HMASTER(fp_hmst), .HMASTLOCK(fp_mlock), .HADDR_S(fp_haddr),
    .HTRANS_S(fp_htrans), .HWRITE_S(fp_hwrite), .HSIZE_S(fp_hsize), .HBURST_S(fp_hburst),
    .HWDATA_S(fp_hwdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge HCLK);
    #2;
  endtask

  task automatic idle_all();
    for (int i = 0; i < int'(NM); i++) begin
      trans[i] = T_IDLE;
      burst[i] = 3'b000;
      addr[i]  = 32'hA000_0000 + 32'(i) * 32'h100;
      wdata[i] = 32'hDA7A_0000 + 32'(i);
    end
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    busreq  = '0;
    lock    = '0;
    hready  = 1'b1;
    idle_all();
    tick();
    tick();
    HRESETn = 1'b1;
  endtask

  initial begin
    // Reset state, no requests
    do_reset();
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("t1_gnt_%0d", c),   64'(rr_gnt),   64'h1);
      chk($sformatf("t1_hmst_%0d", c),  64'(rr_hmst),  64'h0);
      chk($sformatf("t1_mlock_%0d", c), 64'(rr_mlock), 64'h0);
      tick();
    end

    // All request, SINGLE NONSEQ: RR rotates, FP stays on master 0
    do_reset();
    for (int i = 0; i < int'(NM); i++) trans[i] = T_NONSEQ;
    busreq = 4'b1111;
    #1;
    chk("t2_gnt_init", 64'(rr_gnt), 64'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      chk($sformatf("t2_rr_gnt_%0d", k),   64'(rr_gnt),    64'(4'(1) << exp_g[k]));
      chk($sformatf("t2_rr_hmst_%0d", k),  64'(rr_hmst),   64'(exp_h[k]));
      chk($sformatf("t2_rr_haddr_%0d", k), 64'(rr_haddr),  64'(32'hA000_0000 + 32'(exp_h[k]) * 32'h100));
      chk($sformatf("t2_rr_wdata_%0d", k), 64'(rr_hwdata), 64'(32'hDA7A_0000 + 32'(exp_d[k])));
      chk($sformatf("t3_fp_gnt_%0d", k),   64'(fp_gnt),    64'h1);
      chk($sformatf("t3_fp_hmst_%0d", k),  64'(fp_hmst),   64'h0);
    end

    // Master 2 INCR4 while master 0 requests from the first beat
    do_reset();
    busreq = 4'b0100;
    tick();
    #1;
    chk("t4_gnt_b",  64'(rr_gnt),  64'h4);
    chk("t4_hmst_b", 64'(rr_hmst), 64'h0);
    tick();
    trans[2] = T_NONSEQ; burst[2] = 3'b011; addr[2] = 32'h0000_2000;
    busreq = 4'b0101;
    #1;
    chk("t4_hmst_nseq",  64'(rr_hmst),   64'h2);
    chk("t4_haddr_nseq", 64'(rr_haddr),  64'h2000);
    chk("t4_hburst",     64'(rr_hburst), 64'h3);
    chk("t4_wdata_pre",  64'(rr_hwdata), 64'hDA7A_0000);
    tick();
    for (int b = 1; b < 4; b++) begin
      trans[2] = T_SEQ; addr[2] = 32'h0000_2000 + 32'(b) * 32'h4;
      #1;
      chk($sformatf("t4_gnt_s%0d", b),   64'(rr_gnt),    64'h4);
      chk($sformatf("t4_hmst_s%0d", b),  64'(rr_hmst),   64'h2);
      chk($sformatf("t4_haddr_s%0d", b), 64'(rr_haddr),  64'(32'h0000_2000 + 32'(b) * 32'h4));
      chk($sformatf("t4_wdata_s%0d", b), 64'(rr_hwdata), 64'hDA7A_0002);
      tick();
    end
    trans[2] = T_IDLE; burst[2] = 3'b000; busreq = 4'b0001;
    #1;
    chk("t4_gnt_end",   64'(rr_gnt),    64'h4);
    chk("t4_wdata_end", 64'(rr_hwdata), 64'hDA7A_0002);
    tick();
    #1;
    chk("t4_gnt_hand",  64'(rr_gnt),  64'h1);
    chk("t4_hmst_hand", 64'(rr_hmst), 64'h2);
    tick();
    #1;
    chk("t4_hmst_new", 64'(rr_hmst), 64'h0);

    // Master 1 locked: three SINGLEs then release to master 0
    do_reset();
    busreq = 4'b0010; lock = 4'b0010;
    tick();
    #1;
    chk("t5_gnt_b",   64'(rr_gnt),   64'h2);
    chk("t5_mlock_b", 64'(rr_mlock), 64'h0);
    tick();
    busreq = 4'b0011;
    for (int t = 0; t < 3; t++) begin
      trans[1] = T_NONSEQ; addr[1] = 32'h0000_3000 + 32'(t) * 32'h4;
      #1;
      chk($sformatf("t5_gnt_%0d", t),   64'(rr_gnt),   64'h2);
      chk($sformatf("t5_hmst_%0d", t),  64'(rr_hmst),  64'h1);
      chk($sformatf("t5_mlock_%0d", t), 64'(rr_mlock), 64'h1);
      tick();
    end
    trans[1] = T_IDLE; lock = '0; busreq = 4'b0001;
    #1;
    chk("t5_gnt_rel", 64'(rr_gnt), 64'h2);
    tick();
    #1;
    chk("t5_gnt_hand",   64'(rr_gnt),   64'h1);
    chk("t5_mlock_hand", 64'(rr_mlock), 64'h0);
    tick();
    #1;
    chk("t5_hmst_new", 64'(rr_hmst), 64'h0);

    // Master 1 INCR8 with a 3-cycle stall at counter value 2, master 3 waiting
    do_reset();
    busreq = 4'b0010;
    tick();
    tick();
    trans[1] = T_NONSEQ; burst[1] = 3'b101; addr[1] = 32'h0000_4000;
    busreq = 4'b1010;
    tick();
    for (int b = 1; b < 6; b++) begin
      trans[1] = T_SEQ; addr[1] = 32'h0000_4000 + 32'(b) * 32'h4;
      #1;
      chk($sformatf("t6_gnt_s%0d", b), 64'(rr_gnt), 64'h2);
      tick();
    end
    addr[1] = 32'h0000_4018; hready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk($sformatf("t6_stall_gnt_%0d", s),  64'(rr_gnt),          64'h2);
      chk($sformatf("t6_stall_hmst_%0d", s), 64'(rr_hmst),         64'h1);
      chk($sformatf("t6_stall_cnt_%0d", s),  64'(u_rr.beat_cnt_q), 64'h2);
      tick();
    end
    hready = 1'b1;
    tick();
    addr[1] = 32'h0000_401C;
    #1;
    chk("t6_cnt_last", 64'(u_rr.beat_cnt_q), 64'h1);
    tick();
    trans[1] = T_IDLE; burst[1] = 3'b000; busreq = 4'b1000;
    #1;
    chk("t6_gnt_done", 64'(rr_gnt),          64'h2);
    chk("t6_cnt_done", 64'(u_rr.beat_cnt_q), 64'h0);
    tick();
    #1;
    chk("t6_gnt_m3", 64'(rr_gnt), 64'h8);
    tick();
    #1;
    chk("t6_hmst_m3", 64'(rr_hmst), 64'h3);

    // Asynchronous reset in the middle of an INCR16 burst
    do_reset();
    busreq = 4'b0100;
    tick();
    tick();
    trans[2] = T_NONSEQ; burst[2] = 3'b111;
    tick();
    trans[2] = T_SEQ;
    #1;
    chk("t7_cnt_pre",  64'(u_rr.beat_cnt_q), 64'hF);
    chk("t7_hmst_pre", 64'(rr_hmst),         64'h2);
    HRESETn = 1'b0;
    #1;
    chk("t7_cnt_rst",  64'(u_rr.beat_cnt_q), 64'h0);
    chk("t7_gnt_rst",  64'(rr_gnt),          64'h1);
    chk("t7_hmst_rst", 64'(rr_hmst),         64'h0);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
